// File: rtl/xcorr_peak_if.sv
// Bus between the peak scanner and its environment: control, buffer read port, result.
interface xcorr_peak_if #(
  parameter int OUT_ADDR_WIDTH = 8,
  parameter int SUM_WIDTH      = 24
);
  logic                          start;
  logic signed [SUM_WIDTH-1:0]   threshold;
  logic [OUT_ADDR_WIDTH-1:0]     rd_addr;
  logic                          rd_en;
  logic signed [SUM_WIDTH-1:0]   rd_data;
  logic                          busy;
  logic                          done;
  logic                          peak_valid;
  logic [OUT_ADDR_WIDTH-1:0]     peak_idx;
  logic signed [SUM_WIDTH-1:0]   peak_val;
  logic signed [OUT_ADDR_WIDTH:0] peak_lag;
  logic                          peak_above;

  modport master (
    output start, threshold, rd_data,
    input  rd_addr, rd_en, busy, done, peak_valid, peak_idx, peak_val, peak_lag, peak_above
  );

  modport slave (
    input  start, threshold, rd_data,
    output rd_addr, rd_en, busy, done, peak_valid, peak_idx, peak_val, peak_lag, peak_above
  );
endinterface

// File: rtl/xcorr_peak.sv
// Scans the lag-indexed correlation buffer once per start and reports the largest entry
// (index, raw value, signed lag) plus a threshold flag.
module xcorr_peak #(
  parameter int OUT_ADDR_WIDTH = 8,
  parameter int SUM_WIDTH      = 24,
  parameter int FIRST_ADDR     = 1,
  parameter bit USE_ABS        = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  xcorr_peak_if.slave  bus
);
  localparam int AW = OUT_ADDR_WIDTH;
  localparam int SW = SUM_WIDTH;
  localparam logic [AW-1:0] FIRST_A = AW'(FIRST_ADDR);
  localparam logic [AW-1:0] LAST_A  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  vld_p0_q;
  logic [AW-1:0]         idx_p0_q;
  logic                  have_best_q, have_best_d;
  logic signed [SW-1:0]  best_val_q, best_val_d;
  logic [AW-1:0]         best_idx_q, best_idx_d;
  logic signed [SW-1:0]  thr_q, thr_d;
  logic                  done_q, done_d;
  logic                  peak_valid_q, peak_valid_d;
  logic                  res_q, res_d;
  logic                  above_q, above_d;
  logic [AW-1:0]         peak_idx_q, peak_idx_d;
  logic signed [SW-1:0]  peak_val_q, peak_val_d;
  logic                  start_ok;

  // One extra bit keeps |-2**(SW-1)| representable.
  function automatic logic signed [SW:0] cmp_key(input logic signed [SW-1:0] v);
    logic signed [SW:0] ext;
    ext = {v[SW-1], v};
    if (USE_ABS && v[SW-1]) return -ext;
    return ext;
  endfunction

  assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = rd_en_q;
    thr_d        = thr_q;
    done_d       = 1'b0;
    peak_valid_d = peak_valid_q;
    res_d        = res_q;
    above_d      = above_q;
    peak_idx_d   = peak_idx_q;
    peak_val_d   = peak_val_q;
    have_best_d  = have_best_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;

    // p0 -> best: first valid word loads unconditionally, later ones only if strictly greater
    if (vld_p0_q && (!have_best_q || (cmp_key(bus.rd_data) > cmp_key(best_val_q)))) begin
      best_val_d  = bus.rd_data;
      best_idx_d  = idx_p0_q;
      have_best_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d      = SCAN;
          rd_addr_d    = FIRST_A;
          rd_en_d      = 1'b1;
          peak_valid_d = 1'b0;
          thr_d        = bus.threshold;
          have_best_d  = 1'b0;
        end
      end
      SCAN: begin
        if (rd_addr_q == LAST_A) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        // Publish once the final word has been folded into the running best.
        if (!vld_p0_q) begin
          state_d      = DONE;
          done_d       = 1'b1;
          peak_valid_d = 1'b1;
          res_d        = 1'b1;
          peak_idx_d   = best_idx_q;
          peak_val_d   = best_val_q;
          above_d      = (best_val_q >= thr_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      vld_p0_q     <= 1'b0;
      have_best_q  <= 1'b0;
      done_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      res_q        <= 1'b0;
      above_q      <= 1'b0;
      peak_idx_q   <= '0;
      peak_val_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      vld_p0_q     <= rd_en_q;
      have_best_q  <= have_best_d;
      done_q       <= done_d;
      peak_valid_q <= peak_valid_d;
      res_q        <= res_d;
      above_q      <= above_d;
      peak_idx_q   <= peak_idx_d;
      peak_val_q   <= peak_val_d;
    end
  end

  // p0: address of the word arriving on rd_data, plus datapath state
  always_ff @(posedge clk) begin
    idx_p0_q   <= rd_addr_q;
    best_val_q <= best_val_d;
    best_idx_q <= best_idx_d;
    thr_q      <= thr_d;
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.busy       = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done       = done_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_idx   = peak_idx_q;
  assign bus.peak_val   = peak_val_q;
  assign bus.peak_above = above_q;
  // 2*idx - 2**AW is {idx,0} with its top bit flipped; held at 0 until a first result exists.
  assign bus.peak_lag   = res_q ? {~peak_idx_q[AW-1], peak_idx_q[AW-2:0], 1'b0} : '0;

endmodule

// File: tb/tb_xcorr_peak.sv
// Bench for xcorr_peak: signed-compare and magnitude-compare instances against a buffer model.
module tb_xcorr_peak;
  logic clk;
  logic rst;

  xcorr_peak_if #(.OUT_ADDR_WIDTH(8), .SUM_WIDTH(24)) if0 ();
  xcorr_peak_if #(.OUT_ADDR_WIDTH(8), .SUM_WIDTH(24)) if1 ();

  xcorr_peak #(.OUT_ADDR_WIDTH(8), .SUM_WIDTH(24), .FIRST_ADDR(1), .USE_ABS(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  xcorr_peak #(.OUT_ADDR_WIDTH(8), .SUM_WIDTH(24), .FIRST_ADDR(1), .USE_ABS(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic signed [23:0] mem0 [256];
  logic signed [23:0] mem1 [256];

  typedef struct {
    int     idx;
    longint val;
    bit     above;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if0.rd_en) if0.rd_data <= mem0[if0.rd_addr];
    if (if1.rd_en) if1.rd_data <= mem1[if1.rd_addr];
  end

  function automatic longint key_of(input bit sel, input longint v);
    if (sel && v < 0) return -v;
    return v;
  endfunction

  function automatic exp_t model(input bit sel, input logic signed [23:0] thr);
    exp_t   r;
    longint v;
    longint bk;
    r.idx = 1;
    r.val = sel ? mem1[1] : mem0[1];
    bk    = key_of(sel, r.val);
    for (int a = 2; a < 256; a++) begin
      v = sel ? mem1[a] : mem0[a];
      if (key_of(sel, v) > bk) begin
        bk    = key_of(sel, v);
        r.idx = a;
        r.val = v;
      end
    end
    r.above = (r.val >= longint'(thr));
    return r;
  endfunction

  task automatic fill(input bit sel, input logic signed [23:0] v);
    for (int a = 0; a < 256; a++) begin
      if (sel) mem1[a] = v;
      else     mem0[a] = v;
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) if1.start = v;
    else     if0.start = v;
  endtask

  // Drives one scan, pushes the model's answer, and watches 300 edges for done pulses.
  task automatic run_scan(input bit sel, input logic signed [23:0] thr, input bit inject,
                          output int done_edge, output int n_done,
                          output bit pv_at_start, output bit busy_at_start);
    exp_q.push_back(model(sel, thr));
    @(negedge clk);
    if (sel) if1.threshold = thr;
    else     if0.threshold = thr;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    pv_at_start   = sel ? if1.peak_valid : if0.peak_valid;
    busy_at_start = sel ? if1.busy : if0.busy;
    done_edge = -1;
    n_done    = 0;
    for (int k = 1; k <= 300; k++) begin
      if (inject && k == 20) set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      if (inject && k == 20) set_start(sel, 1'b0);
      if (sel ? if1.done : if0.done) begin
        n_done++;
        if (done_edge < 0) done_edge = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if0.busy); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if0.done); end
    checks++; if (if0.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", if0.rd_en); end
    checks++; if (if0.rd_addr !== 8'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", if0.rd_addr); end
    checks++; if (if0.peak_valid !== 1'b0) begin errors++; $display("FAIL reset_peak_valid got %b exp 0", if0.peak_valid); end
    checks++; if (if0.peak_idx !== 8'd0) begin errors++; $display("FAIL reset_peak_idx got %0d exp 0", if0.peak_idx); end
    checks++; if (if0.peak_val !== 24'sd0) begin errors++; $display("FAIL reset_peak_val got %0d exp 0", if0.peak_val); end
    checks++; if (if0.peak_lag !== 9'sd0) begin errors++; $display("FAIL reset_peak_lag got %0d exp 0", if0.peak_lag); end
    checks++; if (if0.peak_above !== 1'b0) begin errors++; $display("FAIL reset_peak_above got %b exp 0", if0.peak_above); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_peak();
    int de, nd; bit pv, bz; exp_t e;
    fill(0, 24'sd0);
    mem0[100] = 24'sd5000;
    run_scan(0, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL single_busy_at_start got %b exp 1", bz); end
    checks++; if (de !== 257) begin errors++; $display("FAIL single_done_edge got %0d exp 257", de); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", nd); end
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL single_idx got %0d exp %0d", if0.peak_idx, e.idx); end
    checks++; if (longint'(if0.peak_val) !== e.val) begin errors++; $display("FAIL single_val got %0d exp %0d", if0.peak_val, e.val); end
    checks++; if (int'(if0.peak_lag) !== 2 * e.idx - 256) begin errors++; $display("FAIL single_lag got %0d exp %0d", if0.peak_lag, 2 * e.idx - 256); end
    checks++; if (if0.peak_above !== e.above) begin errors++; $display("FAIL single_above got %b exp %b", if0.peak_above, e.above); end
    checks++; if (if0.peak_valid !== 1'b1 || if0.busy !== 1'b0) begin errors++; $display("FAIL single_valid_busy got %b%b exp 10", if0.peak_valid, if0.busy); end
  endtask

  task automatic test_tie();
    int de, nd; bit pv, bz; exp_t e;
    fill(0, -24'sd3);
    mem0[10]  = 24'sd777;
    mem0[200] = 24'sd777;
    run_scan(0, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL tie_idx got %0d exp %0d", if0.peak_idx, e.idx); end
    checks++; if (longint'(if0.peak_val) !== e.val) begin errors++; $display("FAIL tie_val got %0d exp %0d", if0.peak_val, e.val); end
    checks++; if (de !== 257) begin errors++; $display("FAIL tie_done_edge got %0d exp 257", de); end
  endtask

  task automatic test_threshold();
    int de, nd; bit pv, bz; exp_t e;
    fill(0, -24'sd1000);
    mem0[255] = -24'sd1;
    run_scan(0, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL thr0_idx got %0d exp %0d", if0.peak_idx, e.idx); end
    checks++; if (longint'(if0.peak_val) !== e.val) begin errors++; $display("FAIL thr0_val got %0d exp %0d", if0.peak_val, e.val); end
    checks++; if (if0.peak_above !== e.above) begin errors++; $display("FAIL thr0_above got %b exp %b", if0.peak_above, e.above); end
    checks++; if (int'(if0.peak_lag) !== 254) begin errors++; $display("FAIL thr0_lag got %0d exp 254", if0.peak_lag); end
    run_scan(0, -24'sd5, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (if0.peak_above !== e.above) begin errors++; $display("FAIL thr5_above got %b exp %b", if0.peak_above, e.above); end
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL thr5_idx got %0d exp %0d", if0.peak_idx, e.idx); end
  endtask

  task automatic test_reset_mid_scan();
    int de, nd, n; bit pv, bz; exp_t e;
    fill(0, 24'sd0);
    mem0[77] = 24'sd42;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (if0.busy !== 1'b0 || if0.rd_en !== 1'b0) begin errors++; $display("FAIL abort_busy_rd_en got %b%b exp 00", if0.busy, if0.rd_en); end
    checks++; if (if0.rd_addr !== 8'd0) begin errors++; $display("FAIL abort_rd_addr got %0d exp 0", if0.rd_addr); end
    checks++; if (if0.peak_valid !== 1'b0 || if0.peak_idx !== 8'd0) begin errors++; $display("FAIL abort_peak got %b/%0d exp 0/0", if0.peak_valid, if0.peak_idx); end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if0.done) n++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 280; k++) begin
      @(posedge clk); #1;
      if (if0.done) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", n); end
    run_scan(0, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (de !== 257) begin errors++; $display("FAIL abort_fresh_edge got %0d exp 257", de); end
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL abort_fresh_idx got %0d exp %0d", if0.peak_idx, e.idx); end
  endtask

  task automatic test_back_to_back();
    int de, nd; bit pv, bz; exp_t e;
    fill(0, 24'sd0);
    mem0[3] = 24'sd9;
    run_scan(0, 24'sd0, 1, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (nd !== 1) begin errors++; $display("FAIL inject_done_count got %0d exp 1", nd); end
    checks++; if (de !== 257) begin errors++; $display("FAIL inject_done_edge got %0d exp 257", de); end
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL inject_idx got %0d exp %0d", if0.peak_idx, e.idx); end
    mem0[3]   = 24'sd0;
    mem0[250] = 24'sd123456;
    run_scan(0, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (pv !== 1'b0 || bz !== 1'b1) begin errors++; $display("FAIL restart_valid_busy got %b%b exp 01", pv, bz); end
    checks++; if (de !== 257) begin errors++; $display("FAIL restart_done_edge got %0d exp 257", de); end
    checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL restart_idx got %0d exp %0d", if0.peak_idx, e.idx); end
    checks++; if (longint'(if0.peak_val) !== e.val) begin errors++; $display("FAIL restart_val got %0d exp %0d", if0.peak_val, e.val); end
  endtask

  task automatic test_abs();
    int de, nd; bit pv, bz; exp_t e;
    fill(1, 24'sd0);
    mem1[30] = -24'sd9000;
    mem1[40] = 24'sd8000;
    run_scan(1, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (int'(if1.peak_idx) !== e.idx) begin errors++; $display("FAIL abs_idx got %0d exp %0d", if1.peak_idx, e.idx); end
    checks++; if (longint'(if1.peak_val) !== e.val) begin errors++; $display("FAIL abs_val got %0d exp %0d", if1.peak_val, e.val); end
    checks++; if (if1.peak_above !== e.above) begin errors++; $display("FAIL abs_above got %b exp %b", if1.peak_above, e.above); end
    checks++; if (de !== 257) begin errors++; $display("FAIL abs_done_edge got %0d exp 257", de); end
    mem1[5] = 24'sh800000;
    run_scan(1, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (int'(if1.peak_idx) !== e.idx) begin errors++; $display("FAIL absmin_idx got %0d exp %0d", if1.peak_idx, e.idx); end
    checks++; if (longint'(if1.peak_val) !== e.val) begin errors++; $display("FAIL absmin_val got %0d exp %0d", if1.peak_val, e.val); end
    checks++; if (int'(if1.peak_lag) !== 2 * e.idx - 256) begin errors++; $display("FAIL absmin_lag got %0d exp %0d", if1.peak_lag, 2 * e.idx - 256); end
  endtask

  task automatic test_random();
    int de, nd; bit pv, bz; exp_t e;
    logic signed [23:0] thr;
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 256; a++) mem0[a] = 24'($urandom);
      thr = 24'($urandom);
      run_scan(0, thr, 0, de, nd, pv, bz);
      e = exp_q.pop_front();
      checks++; if (int'(if0.peak_idx) !== e.idx) begin errors++; $display("FAIL rand%0d_idx got %0d exp %0d", r, if0.peak_idx, e.idx); end
      checks++; if (longint'(if0.peak_val) !== e.val) begin errors++; $display("FAIL rand%0d_val got %0d exp %0d", r, if0.peak_val, e.val); end
      checks++; if (if0.peak_above !== e.above) begin errors++; $display("FAIL rand%0d_above got %b exp %b", r, if0.peak_above, e.above); end
    end
    for (int a = 0; a < 256; a++) mem1[a] = 24'($urandom);
    run_scan(1, 24'sd0, 0, de, nd, pv, bz);
    e = exp_q.pop_front();
    checks++; if (int'(if1.peak_idx) !== e.idx) begin errors++; $display("FAIL randabs_idx got %0d exp %0d", if1.peak_idx, e.idx); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    if0.start = 1'b0; if0.threshold = '0;
    if1.start = 1'b0; if1.threshold = '0;
    test_reset();
    test_single_peak();
    test_tie();
    test_threshold();
    test_reset_mid_scan();
    test_back_to_back();
    test_abs();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
